cfs_apb_slave_regs: RTL and testbench



---
 rtl/cfs_apb_slave_regs.sv | 135 +++++++++++++
 tb/tb_cfs_apb_slave_regs.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfs_apb_slave_regs.sv
// APB completer with eight registers: six RW, a transfer counter and a constant ID.
// Fixed wait-state insertion; writes commit and the counter advances only on the completing edge.
module cfs_apb_slave_regs #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 16,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] ID_VALUE    = 16'hA5B0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);
    localparam int                    BYTES      = DATA_WIDTH / 8;
    localparam int                    OFFW       = $clog2(BYTES);
    localparam logic [DATA_WIDTH-1:0] ID_EXT     = DATA_WIDTH'(ID_VALUE);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(8 * BYTES);
    localparam logic [3:0]            WS         = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [2:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] regs_q [6];
    logic [DATA_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
    logic                  load, complete;
    logic [DATA_WIDTH-1:0] rd_val, prdata_d;
    logic                  pready_d, pslverr_d;
    logic [2:0]            setup_idx;
    logic                  setup_err;

    assign setup_idx = paddr[OFFW +: 3];
    assign setup_err = (|paddr[OFFW-1:0]) || (paddr >= ADDR_LIMIT) ||
                       (pwrite && setup_idx >= 3'd6);

    // Next-state: a setup phase seen in any state (re)loads the transfer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        err_d    = err_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        load     = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: load = psel && !penable;
            S_WAIT, S_READY: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (!penable) begin
                    load = 1'b1;
                end else if (state_q == S_WAIT) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_READY;
                end else begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            wr_d    = pwrite;
            err_d   = setup_err;
            idx_d   = setup_idx;
            wdata_d = pwdata;
            if (WS == 4'd0) begin
                state_d = S_READY;
                cnt_d   = 4'd0;
            end else begin
                state_d = S_WAIT;
                cnt_d   = WS;
            end
        end
    end

    // Registered outputs are computed from the next state so they line up with READY.
    always_comb begin
        rd_val = '0;
        case (idx_d)
            3'd6:    rd_val = xfer_cnt_q;
            3'd7:    rd_val = ID_EXT;
            default: begin
                for (int i = 0; i < 6; i++)
                    if (idx_d == 3'(i)) rd_val = regs_q[i];
            end
        endcase
        pready_d   = (state_d == S_READY);
        pslverr_d  = pready_d && err_d;
        prdata_d   = (pready_d && !err_d && !wr_d) ? rd_val : '0;
        xfer_cnt_d = xfer_cnt_q + DATA_WIDTH'(complete);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= 3'd0;
            wdata_q    <= '0;
            xfer_cnt_q <= '0;
            prdata     <= '0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            for (int i = 0; i < 6; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            xfer_cnt_q <= xfer_cnt_d;
            prdata     <= prdata_d;
            pready     <= pready_d;
            pslverr    <= pslverr_d;
            if (complete && wr_q && !err_q) begin
                for (int i = 0; i < 6; i++)
                    if (idx_q == 3'(i)) regs_q[i] <= wdata_q;
            end
        end
    end
endmodule

// File: tb/tb_cfs_apb_slave_regs.sv
// Randomized APB bench for cfs_apb_slave_regs against a transfer-level register model.
module tb_cfs_apb_slave_regs;
    localparam int WS = 1;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [15:0] pwdata = '0;
    logic [15:0] prdata;
    logic        pready, pslverr;

    always #5 pclk = ~pclk;

    cfs_apb_slave_regs #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (16),
        .WAIT_STATES(WS),
        .ID_VALUE   (16'hA5B0)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr)
    );

    int          n_tests = 0, n_fail = 0;
    logic        exp_pready = 1'b0, exp_pslverr = 1'b0, exp_dchk = 1'b1;
    logic [15:0] exp_prdata = '0;
    logic [15:0] m_regs [0:7];
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        check("pready", 32'(pready), 32'(exp_pready));
        check("pslverr", 32'(pslverr), 32'(exp_pslverr));
        if (exp_dchk) check("prdata", 32'(prdata), 32'(exp_prdata));
    end

    task automatic exp_idle();
        exp_pready = 1'b0; exp_pslverr = 1'b0; exp_prdata = '0; exp_dchk = 1'b1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_cnt = '0;
    endtask

    function automatic bit m_err(input bit w, input logic [31:0] a);
        return (a % 2 != 0) || (a >= 16) || (w && (a / 2 == 6 || a / 2 == 7));
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] idx);
        if (idx == 3'd7) return 16'hA5B0;
        if (idx == 3'd6) return m_cnt;
        return m_regs[idx];
    endfunction

    // One full transfer starting at the next falling edge; returns the ready-cycle response.
    task automatic xfer(input bit w, input logic [31:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output bit er);
        bit          e;
        logic [15:0] v;
        logic [2:0]  idx;
        e   = m_err(w, a);
        idx = 3'(a / 2);
        v   = (e || w) ? 16'h0 : m_read(idx);
        rd  = '0; er = 1'b0;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        for (int c = 1; c <= WS + 1; c++) begin
            @(posedge pclk); #1;
            if (c == WS + 1) begin
                exp_pready = 1'b1; exp_pslverr = e; exp_prdata = v; exp_dchk = !w || e;
            end else begin
                exp_idle();
            end
            @(negedge pclk);
            penable = 1'b1; paddr = $urandom; pwdata = 16'($urandom);
            if (c == WS + 1) begin rd = prdata; er = pslverr; end
        end
        @(posedge pclk); #1;
        exp_idle();
        m_cnt = m_cnt + 16'd1;
        if (w && !e) m_regs[idx] = d;
    endtask

    task automatic xfer_abort(input bit w, input logic [31:0] a, input logic [15:0] d);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk); #1; exp_idle();
        @(negedge pclk); psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1; exp_idle();
    endtask

    task automatic idle();
        @(negedge pclk); psel = 1'b0; penable = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge pclk); psel = 1'b0; penable = 1'b0; preset = 1'b1;
        m_reset(); exp_idle();
        @(negedge pclk); preset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd, rd2;
        bit          er, w;
        logic [31:0] a;
        m_reset(); exp_idle();
        #3;
        check("reset_pready", 32'(pready), 32'h0);
        check("reset_pslverr", 32'(pslverr), 32'h0);
        check("reset_prdata", 32'(prdata), 32'h0);
        @(negedge pclk); preset = 1'b0;

        // ID register
        xfer(1'b0, 32'd14, 16'h0, rd, er);
        check("id_value", 32'(rd), 32'hA5B0);
        check("id_err", 32'(er), 32'h0);

        // write then back-to-back readback, counter from fresh reset
        reset_pulse();
        xfer(1'b1, 32'd4, 16'h1234, rd, er);
        check("wr_err", 32'(er), 32'h0);
        xfer(1'b0, 32'd4, 16'h0, rd, er);
        check("readback", 32'(rd), 32'h1234);
        xfer(1'b0, 32'd12, 16'h0, rd, er);
        check("cnt_after_2", 32'(rd), 32'd2);

        // error responses
        xfer(1'b1, 32'd3, 16'h5555, rd, er);
        check("err_misaligned", 32'(er), 32'h1);
        xfer(1'b1, 32'd16, 16'h6666, rd, er);
        check("err_out_of_range", 32'(er), 32'h1);
        xfer(1'b1, 32'd14, 16'h7777, rd, er);
        check("err_ro_reg7", 32'(er), 32'h1);
        xfer(1'b0, 32'd12, 16'h0, rd, er);
        check("cnt_after_errors", 32'(rd), 32'd6);
        xfer(1'b0, 32'd2, 16'h0, rd, er);
        check("reg1_untouched", 32'(rd), 32'h0);
        xfer(1'b0, 32'd0, 16'h0, rd, er);
        check("reg0_untouched", 32'(rd), 32'h0);
        xfer(1'b0, 32'd4, 16'h0, rd, er);
        check("reg2_kept", 32'(rd), 32'h1234);
        xfer(1'b0, 32'd14, 16'h0, rd, er);
        check("reg7_untouched", 32'(rd), 32'hA5B0);

        // counter successive reads and wrap
        xfer(1'b0, 32'd12, 16'h0, rd, er);
        xfer(1'b0, 32'd12, 16'h0, rd2, er);
        check("cnt_k", 32'(rd), 32'd11);
        check("cnt_k_plus_1", 32'(rd2), 32'd12);
        idle();
        force dut.xfer_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(posedge pclk);
        @(negedge pclk);
        release dut.xfer_cnt_q;
        xfer(1'b0, 32'd12, 16'h0, rd, er);
        check("cnt_ffff", 32'(rd), 32'hFFFF);
        xfer(1'b0, 32'd12, 16'h0, rd, er);
        check("cnt_wrapped", 32'(rd), 32'h0);

        // abort in WAIT
        xfer_abort(1'b1, 32'd0, 16'hBEEF);
        xfer(1'b0, 32'd0, 16'h0, rd, er);
        check("abort_no_write", 32'(rd), 32'h0);
        xfer(1'b0, 32'd12, 16'h0, rd, er);
        check("abort_no_count", 32'(rd), 32'd2);

        // reset during WAIT of a write to reg 1
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd2; pwdata = 16'hCAFE;
        @(posedge pclk); #1; exp_idle();
        @(negedge pclk); penable = 1'b1;
        #2; preset = 1'b1; m_reset();
        #1;
        check("rst_wait_pready", 32'(pready), 32'h0);
        check("rst_wait_pslverr", 32'(pslverr), 32'h0);
        check("rst_wait_prdata", 32'(prdata), 32'h0);
        @(negedge pclk); psel = 1'b0; penable = 1'b0; preset = 1'b0;
        xfer(1'b0, 32'd2, 16'h0, rd, er);
        check("rst_reg1_zero", 32'(rd), 32'h0);
        xfer(1'b1, 32'd2, 16'hCAFE, rd, er);
        xfer(1'b0, 32'd2, 16'h0, rd, er);
        check("rst_rewrite", 32'(rd), 32'hCAFE);

        // reset while PREADY is high drops the outputs without waiting for a clock
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'd14;
        for (int c = 1; c <= WS + 1; c++) begin
            @(posedge pclk); #1;
            if (c == WS + 1) begin
                exp_pready = 1'b1; exp_pslverr = 1'b0; exp_prdata = 16'hA5B0; exp_dchk = 1'b1;
            end else begin
                exp_idle();
            end
            if (c <= WS) begin @(negedge pclk); penable = 1'b1; end
        end
        check("ready_before_rst", 32'(pready), 32'h1);
        #1; preset = 1'b1; exp_idle(); m_reset();
        #1;
        check("rst_ready_pready", 32'(pready), 32'h0);
        check("rst_ready_prdata", 32'(prdata), 32'h0);
        @(negedge pclk); psel = 1'b0; penable = 1'b0; preset = 1'b0;

        // randomized traffic
        for (int t = 0; t < 250; t++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 19));
            if ($urandom_range(0, 9) == 0) xfer_abort(w, a, 16'($urandom));
            else xfer(w, a, 16'($urandom), rd, er);
            repeat ($urandom_range(0, 2)) idle();
        end
        idle();
        xfer(1'b0, 32'd12, 16'h0, rd, er);
        idle();
        @(negedge pclk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
